// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone B3 classic GPIO slave with input synchronisers,
// atomic set/clear of the output register and per-pin edge/level interrupts
// merged into a single registered, active-high irq_o.
module wb_gpio_irq #(
    parameter int unsigned           GPIO_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [GPIO_WIDTH-1:0] DIR_RESET   = '0
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic [3:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);

    localparam int unsigned W          = GPIO_WIDTH;
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef enum logic [3:0] {
        REG_OUT      = 4'd0,
        REG_DIR      = 4'd1,
        REG_IN       = 4'd2,
        REG_OUT_SET  = 4'd3,
        REG_OUT_CLR  = 4'd4,
        REG_IRQ_EN   = 4'd5,
        REG_IRQ_TYPE = 4'd6,
        REG_IRQ_POL  = 4'd7,
        REG_IRQ_STAT = 4'd8
    } reg_idx_e;

    reg_idx_e                      reg_idx;
    logic                          bus_req;
    logic                          adr_ok;
    logic                          wr_en;
    logic [31:0]                   lane_mask;
    logic [W-1:0]                  wr_bits;
    logic [W-1:0]                  keep_bits;
    logic [31:0]                   rd_data;

    logic [W-1:0]                  out_q;
    logic [W-1:0]                  dir_q;
    logic [W-1:0]                  irq_en_q;
    logic [W-1:0]                  irq_type_q;
    logic [W-1:0]                  irq_pol_q;
    logic [W-1:0]                  irq_stat_q;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  pin_in;
    logic [W-1:0]                  pin_hist_q;
    logic [ARM_W-1:0]              arm_cnt_q;
    logic                          armed;
    logic [W-1:0]                  edge_hit;
    logic [W-1:0]                  level_hit;
    logic [W-1:0]                  set_bits;
    logic [W-1:0]                  w1c_bits;
    logic                          unused_ok;

    // A new request is only accepted while no response is on the bus, which
    // turns a held strobe into the ack, gap, ack pattern.
    assign reg_idx   = reg_idx_e'(wb_adr_i);
    assign bus_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign adr_ok    = (wb_adr_i <= 4'd8);
    assign wr_en     = bus_req & wb_we_i & adr_ok;
    assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wr_bits   = wb_dat_i[W-1:0] & lane_mask[W-1:0];
    assign keep_bits = ~lane_mask[W-1:0];

    assign wb_rty_o   = 1'b0;
    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;

    // Cycle type, burst type and data/lane bits above the pin count carry no meaning here.
    assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_dat_i, lane_mask};

    // Read multiplexer; write-only and unmapped indices read as zero.
    // NOTE: rd_data gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_OUT:      rd_data[W-1:0] = out_q;
            REG_DIR:      rd_data[W-1:0] = dir_q;
            REG_IN:       rd_data[W-1:0] = pin_in;
            REG_IRQ_EN:   rd_data[W-1:0] = irq_en_q;
            REG_IRQ_TYPE: rd_data[W-1:0] = irq_type_q;
            REG_IRQ_POL:  rd_data[W-1:0] = irq_pol_q;
            REG_IRQ_STAT: rd_data[W-1:0] = irq_stat_q;
            default:      rd_data = '0;
        endcase
    end

    // Bus response: one-cycle ack or err, with read data valid only alongside ack.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_req & adr_ok;
            wb_err_o <= bus_req & ~adr_ok;
            wb_dat_o <= (bus_req & adr_ok) ? rd_data : '0;
        end
    end

    // Configuration registers, honouring byte lanes; writes land on the ack edge.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            out_q      <= OUT_RESET;
            dir_q      <= DIR_RESET;
            irq_en_q   <= '0;
            irq_type_q <= '0;
            irq_pol_q  <= '0;
        end else if (wr_en) begin
            case (reg_idx)
                REG_OUT:      out_q      <= (out_q & keep_bits) | wr_bits;
                REG_OUT_SET:  out_q      <= out_q | wr_bits;
                REG_OUT_CLR:  out_q      <= out_q & ~wr_bits;
                REG_DIR:      dir_q      <= (dir_q & keep_bits) | wr_bits;
                REG_IRQ_EN:   irq_en_q   <= (irq_en_q & keep_bits) | wr_bits;
                REG_IRQ_TYPE: irq_type_q <= (irq_type_q & keep_bits) | wr_bits;
                REG_IRQ_POL:  irq_pol_q  <= (irq_pol_q & keep_bits) | wr_bits;
                default:      ;
            endcase
        end
    end

    // Input synchroniser chain plus a one-cycle history of its output for edge detection.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            sync_q     <= '0;
            pin_hist_q <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            end else begin
                sync_q <= gpio_i;
            end
            pin_hist_q <= pin_in;
        end
    end

    assign pin_in = sync_q[SYNC_STAGES-1];

    // Arm counter: the chain and history hold reset zeros, not pin data, until
    // they have filled, so event detection waits until both are valid.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            arm_cnt_q <= '0;
        end else if (!armed) begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
        end
    end

    assign armed     = (arm_cnt_q == ARM_W'(ARM_CYCLES));
    assign edge_hit  = (irq_pol_q & pin_in & ~pin_hist_q) | (~irq_pol_q & ~pin_in & pin_hist_q);
    assign level_hit = ~(pin_in ^ irq_pol_q);
    assign set_bits  = armed ? ((irq_type_q & edge_hit) | (~irq_type_q & level_hit)) : '0;
    assign w1c_bits  = (wr_en && reg_idx == REG_IRQ_STAT) ? wr_bits : '0;

    // Sticky status with write-one-to-clear; a same-cycle set beats the clear.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            irq_stat_q <= '0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~w1c_bits) | set_bits;
        end
    end

    // Registered interrupt request from the enabled status bits.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(irq_stat_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: directed checks with literal expectations, then a random
// bus/pin phase, all compared every cycle against a behavioural model.
module tb_wb_gpio_irq;

    localparam int         S       = 2;
    localparam logic [7:0] OUT_RST = 8'hA5;
    localparam logic [7:0] DIR_RST = 8'h0F;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_dir_o;
    logic        irq_o;

    int tests  = 0;
    int failed = 0;

    always #5 wb_clk = ~wb_clk;

    wb_gpio_irq #(
        .GPIO_WIDTH (8),
        .SYNC_STAGES(S),
        .OUT_RESET  (OUT_RST),
        .DIR_RESET  (DIR_RST)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cti_i  (wb_cti_i),
        .wb_bte_i  (wb_bte_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_rty_o  (wb_rty_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_dir_o(gpio_dir_o),
        .irq_o     (irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            if (failed <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_out, m_dir, m_en, m_typ, m_pol, m_stat;
    logic        m_irq, m_ack, m_err;
    logic [31:0] m_dat;
    logic [7:0]  pin_hist[$];   // pin samples, newest first
    int          since;         // clock edges since reset release
    bit          m_valid = 1'b0;

    always @(posedge wb_clk) begin
        logic [7:0]  cur, prv, ev, lanes, wbits;
        logic        req, hit, irq_next;
        logic [31:0] rd;
        if (!wb_rst_n) begin
            m_out = OUT_RST; m_dir = DIR_RST;
            m_en = 0; m_typ = 0; m_pol = 0; m_stat = 0;
            m_irq = 0; m_ack = 0; m_err = 0; m_dat = 0;
            pin_hist.delete();
            for (int i = 0; i < 8; i++) pin_hist.push_back(8'h00);
            since   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            // IN shows the pin as sampled S edges ago; the previous IN one edge before that.
            cur = pin_hist[S-1];
            prv = pin_hist[S];
            if (since < 1000) since++;
            ev = 8'h00;
            if (since >= S + 2) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_typ[i]) ev[i] = m_pol[i] ? (cur[i] && !prv[i]) : (!cur[i] && prv[i]);
                    else          ev[i] = (cur[i] == m_pol[i]);
                end
            end
            req = wb_cyc_i && wb_stb_i && !m_ack && !m_err;
            hit = req && (wb_adr_i <= 4'd8);
            rd  = 32'h0;
            if (hit) begin
                case (wb_adr_i)
                    4'd0: rd = {24'h0, m_out};
                    4'd1: rd = {24'h0, m_dir};
                    4'd2: rd = {24'h0, cur};
                    4'd5: rd = {24'h0, m_en};
                    4'd6: rd = {24'h0, m_typ};
                    4'd7: rd = {24'h0, m_pol};
                    4'd8: rd = {24'h0, m_stat};
                    default: rd = 32'h0;
                endcase
            end
            irq_next = |(m_stat & m_en);
            lanes = wb_sel_i[0] ? 8'hFF : 8'h00;
            wbits = wb_dat_i[7:0] & lanes;
            if (hit && wb_we_i) begin
                case (wb_adr_i)
                    4'd0: m_out  = (m_out & ~lanes) | wbits;
                    4'd1: m_dir  = (m_dir & ~lanes) | wbits;
                    4'd3: m_out  = m_out | wbits;
                    4'd4: m_out  = m_out & ~wbits;
                    4'd5: m_en   = (m_en & ~lanes) | wbits;
                    4'd6: m_typ  = (m_typ & ~lanes) | wbits;
                    4'd7: m_pol  = (m_pol & ~lanes) | wbits;
                    4'd8: m_stat = m_stat & ~wbits;
                    default: ;
                endcase
            end
            m_stat = m_stat | ev;
            m_ack  = hit;
            m_err  = req && !hit;
            m_dat  = rd;
            m_irq  = irq_next;
            pin_hist.push_front(gpio_i);
            if (pin_hist.size() > 8) void'(pin_hist.pop_back());
        end
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge wb_clk) begin
        if (m_valid) begin
            check("ack",      {31'b0, wb_ack_o}, {31'b0, m_ack});
            check("err",      {31'b0, wb_err_o}, {31'b0, m_err});
            check("rty",      {31'b0, wb_rty_o}, 32'h0);
            check("dat",      wb_dat_o,          m_dat);
            check("gpio_o",   {24'h0, gpio_o},   {24'h0, m_out});
            check("gpio_dir", {24'h0, gpio_dir_o}, {24'h0, m_dir});
            check("irq",      {31'b0, irq_o},    {31'b0, m_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wb_clk);
            #1;
        end
    endtask

    task automatic bus(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, output logic [31:0] rd, output logic ok, output logic er);
        int n;
        n = 0;
        while ((wb_ack_o || wb_err_o) && n < 4) begin
            tick(1);
            n++;
        end
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 8);
        rd = wb_dat_o; ok = wb_ack_o; er = wb_err_o;
        check("bus_response", {31'b0, ok | er}, 32'h1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        ok, er;

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        bus(adr, dat, 4'hF, 1'b1, rd, ok, er);
    endtask

    task automatic rdchk(input string name, input logic [3:0] adr, input logic [31:0] exp);
        bus(adr, 32'h0, 4'hF, 1'b0, rd, ok, er);
        check(name, rd, exp);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        wb_rst_n = 1'b0;
        wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; wb_we_i = 0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        gpio_i   = 8'hFF;
        repeat (3) @(posedge wb_clk);
        #1 wb_rst_n = 1'b1;

        // Reset values
        check("rst_gpio_o",   {24'h0, gpio_o},     32'hA5);
        check("rst_gpio_dir", {24'h0, gpio_dir_o}, 32'h0F);
        check("rst_irq",      {31'b0, irq_o},      32'h0);
        for (int i = 5; i <= 8; i++) rdchk("rst_read", 4'(i), 32'h0);
        rdchk("in_read", 4'd2, 32'hFF);

        // OUT, atomic set/clear, byte lanes
        wr(4'd0, 32'h0F);
        wr(4'd3, 32'hF0);
        wr(4'd4, 32'h11);
        tick(1);
        check("out_set_clr", {24'h0, gpio_o}, 32'hEE);
        bus(4'd0, 32'hFFFFFF00, 4'b0001, 1'b1, rd, ok, er);
        tick(1);
        check("out_lane", {24'h0, gpio_o}, 32'h00);
        bus(4'd1, 32'h0000_3C00, 4'b0010, 1'b1, rd, ok, er);
        tick(1);
        check("dir_lane_off", {24'h0, gpio_dir_o}, 32'h0F);

        // Unmapped index: err only, no state change
        bus(4'd9, 32'hDEADBEEF, 4'hF, 1'b1, rd, ok, er);
        check("err_set",   {31'b0, er}, 32'h1);
        check("err_noack", {31'b0, ok}, 32'h0);
        tick(1);
        check("err_nochg", {24'h0, gpio_o}, 32'h00);

        // Held strobe: ack, gap, ack, gap
        wb_adr_i = 4'd0; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("hold_ack", {31'b0, wb_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(1);

        // Rising-edge interrupt on pin 3
        wr(4'd6, 32'h08);
        wr(4'd7, 32'h08);
        wr(4'd5, 32'h08);
        gpio_i = 8'hF7;
        tick(6);
        rdchk("edge_idle_stat", 4'd8, 32'h00);
        gpio_i = 8'hFF;
        for (int k = 1; k <= S + 2; k++) begin
            tick(1);
            if (k == S + 1) check("edge_irq_early", {31'b0, irq_o}, 32'h0);
            if (k == S + 2) check("edge_irq_set",   {31'b0, irq_o}, 32'h1);
        end
        rdchk("edge_stat", 4'd8, 32'h08);
        wr(4'd8, 32'h08);
        check("w1c_irq_ackcyc", {31'b0, irq_o}, 32'h1);
        tick(1);
        check("w1c_irq_drop", {31'b0, irq_o}, 32'h0);

        // Level-low interrupt on pin 0
        wr(4'd5, 32'h00);
        wr(4'd7, 32'h00);
        wr(4'd6, 32'h00);
        wr(4'd8, 32'hFF);
        gpio_i = 8'hFE;
        wr(4'd5, 32'h01);
        tick(S + 3);
        check("level_irq", {31'b0, irq_o}, 32'h1);
        wr(4'd8, 32'h01);
        tick(2);
        check("level_persist", {31'b0, irq_o}, 32'h1);
        rdchk("level_stat", 4'd8, 32'h01);
        gpio_i = 8'hFF;
        tick(S + 2);
        wr(4'd8, 32'h01);
        tick(1);
        check("level_clear", {31'b0, irq_o}, 32'h0);

        // Reset while a request is pending
        wb_adr_i = 4'd0; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_rst_n = 1'b0;
        tick(1);
        check("rst_drop_ack", {31'b0, wb_ack_o}, 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(1);
        wb_rst_n = 1'b1;
        check("rst2_gpio_o", {24'h0, gpio_o}, 32'hA5);

        // Pins held high through reset: no spurious events once armed
        rdchk("arm_stat0", 4'd8, 32'h00);
        wr(4'd6, 32'hFF);
        wr(4'd7, 32'hFF);
        wr(4'd5, 32'hFF);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("arm_irq", {31'b0, irq_o}, 32'h0);
        end
        rdchk("arm_stat", 4'd8, 32'h00);

        // Random bus traffic and pin activity, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            wb_rst_n = ($urandom_range(0, 599) != 0);
            wb_cyc_i = 1'($urandom_range(0, 1));
            wb_stb_i = wb_cyc_i & 1'($urandom_range(0, 3) != 0);
            wb_we_i  = 1'($urandom_range(0, 1));
            wb_adr_i = 4'($urandom_range(0, 10));
            wb_dat_i = $urandom;
            wb_sel_i = 4'($urandom_range(0, 15));
            wb_cti_i = 3'($urandom_range(0, 7));
            wb_bte_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) gpio_i = gpio_i ^ (8'h01 << $urandom_range(0, 7));
            tick(1);
        end
        wb_rst_n = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
Parametrised Wishbone B3 GPIO slave. It is the successor to the fixed 8-bit gpio block on the SoC interconnect and replaces it at the gpio slave port. It adds:
- configurable width
- input synchronisers
- atomic set/clear of outputs
- per-pin edge/level, polarity-selectable interrupts, merged into one irq_o that drives a mor1kx irq_i line

Parameters:
GPIO_WIDTH, 8, number of pins (1..32); unused data bits read 0 and ignore writes
SYNC_STAGES, 2, flip-flop stages on gpio_i (2..4)
OUT_RESET, 0, reset value of OUT register (GPIO_WIDTH bits)
DIR_RESET, 0, reset value of DIR register (1 = output)

Ports:
wb_clk  in  1  system clock; all logic on rising edge
wb_rst_n  in  1  synchronous active-low reset
wb_adr_i  in  4  word index of register
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables, bit n covers dat[8n+7:8n]
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type (ignored; every access treated as classic)
wb_bte_i  in  2  burst type (ignored)
wb_dat_o  out  32  read data
wb_ack_o  out  1  access acknowledge
wb_err_o  out  1  unmapped-address error
wb_rty_o  out  1  tied 0
gpio_i  in  GPIO_WIDTH  asynchronous pin inputs
gpio_o  out  GPIO_WIDTH  OUT register
gpio_dir_o  out  GPIO_WIDTH  DIR register
irq_o  out  1  registered interrupt request, level, active-high

Behaviour:
- Reset (wb_rst_n=0 at clock edge):
  - wb_dat_o=0, wb_ack_o=0, wb_err_o=0, irq_o=0
  - gpio_o=OUT_RESET, gpio_dir_o=DIR_RESET
  - IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_STATUS, sync chain and edge history all 0
  - Reset mid-transaction drops any pending ack.
- Register map (word index):
  - 0 OUT rw
  - 1 DIR rw
  - 2 IN ro (synchronised gpio_i, independent of DIR)
  - 3 OUT_SET wo (OUT |= data)
  - 4 OUT_CLR wo (OUT &= ~data)
  - 5 IRQ_EN rw
  - 6 IRQ_TYPE rw (1=edge, 0=level)
  - 7 IRQ_POL rw (1=rising/high, 0=falling/low)
  - 8 IRQ_STATUS r/w1c
  - Write-only registers read 0. Writes to IN are ignored but acked.
- Bus handshake:
  - When cyc&stb and no ack/err is currently asserted, assert exactly one of ack/err on the next cycle for one cycle, with wb_dat_o valid in that same cycle.
  - An index >8 gives err instead of ack; no state changes.
  - The write takes effect on the edge that raises ack. Byte lanes with sel=0 are untouched.
  - Back-to-back strobes are acked on alternate cycles: ack, gap, ack.
  - wb_dat_o is 0 when no ack is asserted.
- Synchroniser: IN reflects a gpio_i change SYNC_STAGES cycles after the sampling edge.
- Edge arming: edge detection compares sync output with a one-cycle history register. It is suppressed until SYNC_STAGES+1 cycles after reset release (arm counter), so static high inputs never fire spurious edges.
- Status, per pin i:
  - Edge mode: STATUS[i] sets on a matching edge.
  - Level mode: STATUS[i] sets every cycle the sync input equals POL[i].
  - STATUS records events regardless of IRQ_EN.
  - W1C clears a bit. A set condition in the same cycle as its W1C wins, so a bit stays 1.
  - Level bits re-set while the level persists.
- irq_o is registered |(STATUS & IRQ_EN). It follows a STATUS change by 1 cycle, and drops 1 cycle after the last enabled bit clears or its enable is removed.
- Total latency from pin edge to irq_o: SYNC_STAGES+2 cycles.

Test Plan:
- Reset with OUT_RESET=8'hA5, DIR_RESET=8'h0F → gpio_o=A5, gpio_dir_o=0F, irq_o=0, and reads of idx 5..8 return 0.
- Write OUT=0x0F; write OUT_SET=0xF0; write OUT_CLR=0x11 → gpio_o=0xEE. With sel=4'b0001, write OUT=0xFFFFFF00 → gpio_o=0x00.
- Read idx 9 → err pulses 1 cycle, ack stays 0, no register changes. Hold stb 4 cycles → ack high on cycles 2 and 4 only.
- Set IRQ_TYPE[3]=1, POL[3]=1, EN[3]=1, then drive gpio_i[3] 0→1 → STATUS=0x08 at SYNC_STAGES+1 and irq_o=1 at SYNC_STAGES+2. W1C 0x08 → irq_o=0 a cycle after the ack.
- Set level mode, POL[0]=0, EN[0]=1, gpio_i[0]=0 → irq_o stays 1 across a W1C of 0x01. Drive gpio_i[0]=1, then W1C → irq_o=0.
- Hold gpio_i=0xFF through reset with edge mode on all pins → STATUS remains 0 for 20 cycles after reset release.
